dma_irq_ctrl: RTL

Interrupt controller that sits directly downstream of the AXI DMA block and consumes its dma_done_o and dma_error_o outputs. It converts them to latched pending bits with per-source enables and keeps saturating event counters. It drives one level interrupt toward the PLIC/CPU. Software controls it through a small flat-signal AXI4-Lite slave (32-bit data, one outstanding read and one outstanding write).

---
 rtl/dma_irq_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_irq_ctrl.sv
// Interrupt controller for the AXI DMA block: rising edges of done/error become W1C pending bits
// and saturating event counts, gated by per-source enables into one registered level interrupt.
module dma_irq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_done_i,
  input  logic              dma_error_i,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              irq_o
);

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] ADDR_ENABLE   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] ADDR_RAW      = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] ADDR_DONE_CNT = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] ADDR_ERR_CNT  = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(32'h14);
  localparam logic [1:0]        RESP_OKAY     = 2'b00;
  localparam logic [1:0]        RESP_SLVERR   = 2'b10;
  localparam logic [CNT_W-1:0]  CNT_MAX       = '1;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Full-width decode: misaligned and unmapped offsets fall through to SLVERR.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    case (addr)
      ADDR_STATUS, ADDR_ENABLE, ADDR_RAW,
      ADDR_DONE_CNT, ADDR_ERR_CNT, ADDR_CTRL: addr_ok = 1'b1;
      default:                                addr_ok = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------- write channel
  wstate_t           wstate_reg, wstate_next;
  logic              aw_held_reg, w_held_reg;
  logic [ADDR_W-1:0] awaddr_reg;
  logic [1:0]        wdata_reg;
  logic              wstrb0_reg;
  logic [1:0]        bresp_reg;

  logic              aw_hs, w_hs, aw_have, w_have;
  logic              wr_commit, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              wr_strb0;
  logic [1:0]        w1c_mask;
  logic              enable_we, cnt_clr;

  // Only byte 0 carries register fields.
  logic              unused_wbits;
  assign unused_wbits = ^{s_wdata[31:2], s_wstrb[3:1]};

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid & s_wready;
  assign aw_have = aw_held_reg | aw_hs;
  assign w_have  = w_held_reg | w_hs;

  // Take a channel straight from the bus when it handshakes in the commit cycle itself.
  assign wr_addr  = aw_held_reg ? awaddr_reg : s_awaddr;
  assign wr_data  = w_held_reg ? wdata_reg : s_wdata[1:0];
  assign wr_strb0 = w_held_reg ? wstrb0_reg : s_wstrb[0];

  assign wr_commit = ~rst & (wstate_reg == W_IDLE) & aw_have & w_have;
  assign wr_en     = wr_commit & wr_strb0 & addr_ok(wr_addr);
  assign w1c_mask  = (wr_en && (wr_addr == ADDR_STATUS)) ? wr_data : 2'b00;
  assign enable_we = wr_en & (wr_addr == ADDR_ENABLE);
  assign cnt_clr   = wr_en & (wr_addr == ADDR_CTRL) & wr_data[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_reg <= W_IDLE;
    end else begin
      wstate_reg <= wstate_next;
    end
  end

  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      W_IDLE:  if (wr_commit) wstate_next = W_RESP;
      W_RESP:  if (s_bready) wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    if (!rst) begin
      case (wstate_reg)
        W_IDLE: begin
          s_awready = ~aw_held_reg;
          s_wready  = ~w_held_reg;
        end
        W_RESP: begin
          s_bvalid = 1'b1;
          s_bresp  = bresp_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb0_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      bresp_reg   <= addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        awaddr_reg  <= s_awaddr;
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= s_wdata[1:0];
        wstrb0_reg <= s_wstrb[0];
      end
    end
  end

  // ---------------------------------------------------------------- event sources
  logic [1:0]       src_in, src_event, pend;
  logic [CNT_W-1:0] cnt_val [2];
  logic [1:0]       enable_reg;
  logic             irq_reg;

  assign src_in = {dma_error_i, dma_done_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic             in_q_reg;
      logic             pend_bit_reg;
      logic [CNT_W-1:0] cnt_bit_reg;

      assign src_event[gi] = src_in[gi] & ~in_q_reg;
      assign pend[gi]      = pend_bit_reg;
      assign cnt_val[gi]   = cnt_bit_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          in_q_reg     <= 1'b0;
          pend_bit_reg <= 1'b0;
          cnt_bit_reg  <= '0;
        end else begin
          in_q_reg     <= src_in[gi];
          // A new event beats a simultaneous W1C.
          pend_bit_reg <= src_event[gi] | (pend_bit_reg & ~w1c_mask[gi]);
          if (cnt_clr) begin
            cnt_bit_reg <= src_event[gi] ? CNT_W'(1) : '0;
          end else if (src_event[gi] && (cnt_bit_reg != CNT_MAX)) begin
            cnt_bit_reg <= cnt_bit_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_reg <= 2'b00;
      irq_reg    <= 1'b0;
    end else begin
      if (enable_we) enable_reg <= wr_data;
      irq_reg <= |(pend & enable_reg);
    end
  end

  assign irq_o = irq_reg & ~rst;

  // ---------------------------------------------------------------- read channel
  rstate_t     rstate_reg, rstate_next;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;
  logic [31:0] rd_mux;
  logic        ar_hs;

  assign ar_hs = s_arvalid & s_arready;

  // Sampled from pre-update state, so same-cycle events and writes are not visible.
  always_comb begin
    rd_mux = '0;
    case (s_araddr)
      ADDR_STATUS:   rd_mux[1:0] = pend;
      ADDR_ENABLE:   rd_mux[1:0] = enable_reg;
      ADDR_RAW:      rd_mux[1:0] = src_in;
      ADDR_DONE_CNT: rd_mux      = 32'(cnt_val[0]);
      ADDR_ERR_CNT:  rd_mux      = 32'(cnt_val[1]);
      default:       rd_mux      = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_reg <= R_IDLE;
    end else begin
      rstate_reg <= rstate_next;
    end
  end

  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE:  if (ar_hs) rstate_next = R_DATA;
      R_DATA:  if (s_rready) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    if (!rst) begin
      case (rstate_reg)
        R_IDLE: s_arready = 1'b1;
        R_DATA: begin
          s_rvalid = 1'b1;
          s_rdata  = rdata_reg;
          s_rresp  = rresp_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_mux;
      rresp_reg <= addr_ok(s_araddr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule
